// File: rtl/seq_control_fsm_if.sv
// Sequencer <-> datapath / memory signal bundle.
// master = sequencer, slave = datapath and memories.
interface seq_control_fsm_if #(
  parameter int PC_W = 8
);
  logic            start;
  logic            imem_ack;
  logic [15:0]     instr;
  logic            dmem_ack;
  logic            alu_zero;
  logic [PC_W-1:0] pc;
  logic            imem_req;
  logic            alu_src_sel;
  logic [3:0]      imm;
  logic [3:0]      rd_addr;
  logic [3:0]      rs_addr;
  logic [3:0]      rt_addr;
  logic [1:0]      alu_op;
  logic            reg_we;
  logic            wb_src_sel;
  logic            dmem_req;
  logic            dmem_we;
  logic            busy;
  logic            halted;
  logic            err;

  modport master (
    input  start, imem_ack, instr, dmem_ack, alu_zero,
    output pc, imem_req, alu_src_sel, imm,
    output rd_addr, rs_addr, rt_addr, alu_op,
    output reg_we, wb_src_sel, dmem_req, dmem_we,
    output busy, halted, err
  );

  modport slave (
    output start, imem_ack, instr, dmem_ack, alu_zero,
    input  pc, imem_req, alu_src_sel, imm,
    input  rd_addr, rs_addr, rt_addr, alu_op,
    input  reg_we, wb_src_sel, dmem_req, dmem_we,
    input  busy, halted, err
  );
endinterface

// File: rtl/seq_control_fsm.sv
// Multi-cycle instruction sequencer for the 16-bit datapath.
// Owns PC and IR; all outputs decode from state and IR only.
module seq_control_fsm #(
  parameter int PC_W     = 8,
  parameter int WAIT_MAX = 15
) (
  input logic               clk,
  input logic               reset,
  seq_control_fsm_if.master bus
);
  localparam int CW = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC,
    S_MEM, S_WB, S_HALT, S_ERR
  } state_t;

  state_t          st, st_n;
  logic [PC_W-1:0] pc_q, pc_n, pc_inc, pc_br;
  logic [15:0]     ir_q, ir_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [3:0]      op;
  logic            is_alu, is_addi, is_lw, is_sw;
  logic            is_beq, is_halt, timeout;

  assign op      = ir_q[15:12];
  assign is_alu  = (op <= 4'h4);
  assign is_addi = (op == 4'h4);
  assign is_lw   = (op == 4'h5);
  assign is_sw   = (op == 4'h6);
  assign is_beq  = (op == 4'h7);
  assign is_halt = (op == 4'hf);

  assign pc_inc  = pc_q + PC_W'(1);
  assign pc_br   = pc_inc + {{(PC_W-4){ir_q[3]}}, ir_q[3:0]};
  assign timeout = (cnt_q == CW'(WAIT_MAX - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st    <= S_IDLE;
      pc_q  <= '0;
      ir_q  <= '0;
      cnt_q <= '0;
    end else begin
      st    <= st_n;
      pc_q  <= pc_n;
      ir_q  <= ir_n;
      cnt_q <= cnt_n;
    end
  end

  always_comb begin
    st_n  = st;
    pc_n  = pc_q;
    ir_n  = ir_q;
    cnt_n = cnt_q;
    unique case (st)
      S_IDLE: begin
        if (bus.start) begin
          st_n  = S_FETCH;
          cnt_n = '0;
        end
      end
      S_FETCH: begin
        if (bus.imem_ack) begin
          ir_n = bus.instr;
          st_n = S_DECODE;
        end else if (timeout) begin
          st_n = S_ERR;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      S_DECODE: st_n = is_halt ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (is_lw || is_sw) begin
          st_n  = S_MEM;
          cnt_n = '0;
        end else if (is_alu) begin
          st_n = S_WB;
        end else begin
          // BEQ compares through the ALU subtract
          pc_n  = (is_beq && bus.alu_zero) ? pc_br : pc_inc;
          st_n  = S_FETCH;
          cnt_n = '0;
        end
      end
      S_MEM: begin
        if (bus.dmem_ack) begin
          if (is_lw) begin
            st_n = S_WB;
          end else begin
            pc_n  = pc_inc;
            st_n  = S_FETCH;
            cnt_n = '0;
          end
        end else if (timeout) begin
          st_n = S_ERR;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      S_WB: begin
        pc_n  = pc_inc;
        st_n  = S_FETCH;
        cnt_n = '0;
      end
      S_HALT:  st_n = S_HALT;
      S_ERR:   st_n = S_ERR;
      default: st_n = S_IDLE;
    endcase
  end

  always_comb begin
    bus.alu_op = 2'b00;
    case (op)
      4'h1, 4'h7: bus.alu_op = 2'b01;
      4'h2:       bus.alu_op = 2'b10;
      4'h3:       bus.alu_op = 2'b11;
      default:    bus.alu_op = 2'b00;
    endcase
  end

  assign bus.pc          = pc_q;
  assign bus.imm         = ir_q[3:0];
  assign bus.rd_addr     = ir_q[11:8];
  assign bus.rs_addr     = ir_q[7:4];
  assign bus.rt_addr     = ir_q[3:0];
  assign bus.imem_req    = (st == S_FETCH);
  assign bus.dmem_req    = (st == S_MEM);
  assign bus.dmem_we     = (st == S_MEM) && is_sw;
  assign bus.alu_src_sel = (st == S_EXEC) &&
                           (is_addi || is_lw || is_sw);
  assign bus.reg_we      = (st == S_WB);
  assign bus.wb_src_sel  = (st == S_WB) && is_lw;
  assign bus.busy        = !(st inside {S_IDLE, S_HALT, S_ERR});
  assign bus.halted      = (st == S_HALT);
  assign bus.err         = (st == S_ERR);
endmodule

// File: tb/tb_seq_control_fsm.sv
// Scoreboard bench for seq_control_fsm: memory responder pushes
// per-instruction expectations, a monitor pops and compares them.
module tb_seq_control_fsm;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_control_fsm_if #(.PC_W(8)) bus();

  seq_control_fsm #(.PC_W(8), .WAIT_MAX(15)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  typedef struct {
    int pc; int rd; int rs; int rt;
    int wr; int mem; int we; int src; int wbsrc;
    int aluop; int chkop; int halt;
    int lat; int dd; int id; int npc;
  } rec_t;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] mem [256];
  int          zq [$];
  rec_t        sb [$];
  bit          i_hold, d_hold, fixed;
  int          nfetch, we_seen;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string nm);
    int ctl;
    ctl = int'({bus.imem_req, bus.alu_src_sel, bus.imm, bus.rd_addr,
                bus.rs_addr, bus.rt_addr, bus.alu_op, bus.reg_we,
                bus.wb_src_sel, bus.dmem_req, bus.dmem_we, bus.busy,
                bus.halted, bus.err});
    chk({nm, "_pc"}, int'(bus.pc), 0);
    chk({nm, "_outs"}, ctl, 0);
  endtask

  // Expected behaviour of one instruction, straight from the ISA rules
  function automatic rec_t model(input int pc, input logic [15:0] w,
                                 input int z, input int dd);
    rec_t r;
    int   op, off;
    r = '{default: 0};
    op = int'(w[15:12]);
    r.pc = pc; r.rd = int'(w[11:8]); r.rs = int'(w[7:4]); r.rt = int'(w[3:0]);
    r.npc = (pc + 1) % 256; r.chkop = 1; r.lat = 3;
    off = (r.rt >= 8) ? r.rt - 16 : r.rt;
    if (op <= 4) begin
      r.wr = 1; r.lat = 4; r.src = (op == 4) ? 1 : 0;
      r.aluop = (op == 4) ? 0 : op;
    end else if (op == 5) begin
      r.wr = 1; r.lat = 5; r.mem = 1; r.src = 1; r.wbsrc = 1;
    end else if (op == 6) begin
      r.lat = 4; r.mem = 1; r.we = 1; r.src = 1;
    end else if (op == 7) begin
      r.aluop = 1;
      if (z != 0) r.npc = (((pc + 1 + off) % 256) + 256) % 256;
    end else if (op == 15) begin
      r.halt = 1; r.npc = pc; r.chkop = 0;
    end else begin
      r.chkop = 0;
    end
    r.dd = (r.mem != 0) ? dd : 0;
    return r;
  endfunction

  // Memory responder: acks after a chosen delay and issues expectations
  initial begin : drv
    int iwait, dwait, cur_dd, mpc, ichosen, z, dd;
    logic [15:0] w;
    rec_t r;
    iwait = -1; dwait = -1; cur_dd = 0; mpc = 0; ichosen = 0;
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    bus.instr = '0; bus.alu_zero = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
      if (reset) begin
        mpc = 0; iwait = -1; dwait = -1;
      end else begin
        if (bus.imem_req && !i_hold) begin
          if (iwait < 0) begin
            iwait = fixed ? 0 : int'($urandom_range(0, 3));
            ichosen = iwait;
          end
          if (iwait == 0) begin
            w = mem[mpc];
            if (w[15:12] == 4'h7 && zq.size() > 0) z = zq.pop_front();
            else z = int'($urandom_range(0, 1));
            dd = fixed ? 2 : int'($urandom_range(0, 3));
            r = model(mpc, w, z, dd);
            r.id = ichosen;
            bus.instr = w;
            bus.alu_zero = (z != 0);
            bus.imem_ack = 1'b1;
            sb.push_back(r);
            mpc = r.npc; cur_dd = r.dd; iwait = -1;
          end else begin
            iwait--;
          end
        end
        if (bus.dmem_req && !d_hold) begin
          if (dwait < 0) dwait = cur_dd;
          if (dwait == 0) begin
            bus.dmem_ack = 1'b1;
            dwait = -1;
          end else begin
            dwait--;
          end
        end
      end
    end
  end

  // Monitor: pops one record per fetch and checks the instruction's life
  initial begin : mon
    rec_t cur, nx;
    bit   have;
    int   cyc, lastf, wecnt, dcnt, dreq;
    have = 0; cyc = 0; lastf = 0; wecnt = 0; dcnt = 0; dreq = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
        have = 0;
      end else begin
        cyc++;
        if (bus.reg_we) we_seen++;
        if (bus.imem_req && bus.imem_ack) begin
          nfetch++;
          if (have) begin
            chk("we_count", wecnt, cur.wr);
            chk("dmem_count", dcnt, cur.mem);
            if (cur.mem != 0) chk("dreq_cycles", dreq, cur.dd + 1);
          end
          chk("sb_avail", int'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            nx = sb.pop_front();
            chk("fetch_pc", int'(bus.pc), nx.pc);
            if (have) chk("gap", cyc - lastf, cur.lat + cur.dd + nx.id);
            cur = nx; have = 1; lastf = cyc;
            wecnt = 0; dcnt = 0; dreq = 0;
          end else begin
            have = 0;
          end
        end else if (have) begin
          if (cyc - lastf == 2) begin
            if (cur.halt != 0) begin
              chk("halted", int'(bus.halted), 1);
              chk("halt_busy", int'(bus.busy), 0);
              chk("halt_pc", int'(bus.pc), cur.pc);
            end else begin
              chk("exec_src", int'(bus.alu_src_sel), cur.src);
              if (cur.chkop != 0) chk("exec_aluop", int'(bus.alu_op), cur.aluop);
              chk("exec_rd", int'(bus.rd_addr), cur.rd);
              chk("exec_rs", int'(bus.rs_addr), cur.rs);
              chk("exec_rt", int'(bus.rt_addr), cur.rt);
              chk("exec_imm", int'(bus.imm), cur.rt);
            end
          end
          if (bus.reg_we) begin
            wecnt++;
            chk("wb_rd", int'(bus.rd_addr), cur.rd);
            chk("wb_src", int'(bus.wb_src_sel), cur.wbsrc);
          end
          if (bus.dmem_req) begin
            dreq++;
            if (bus.dmem_ack) begin
              dcnt++;
              chk("dmem_we", int'(bus.dmem_we), cur.we);
              chk("dmem_rs", int'(bus.rs_addr), cur.rs);
              chk("dmem_off", int'(bus.imm), cur.rt);
            end
          end
        end
      end
    end
  end

  task automatic run_prog();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_halt(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (bus.halted) break;
    end
    chk("halt_reached", int'(bus.halted), 1);
  endtask

  initial begin : main
    int n, we0;
    reset = 1'b1; bus.start = 1'b0;
    i_hold = 0; d_hold = 0; fixed = 1; nfetch = 0; we_seen = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h8000;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset_state");

    // Directed program with fixed timing: ALU, LW with slow ack, branches
    mem[0] = 16'h4105; mem[1] = 16'h0211; mem[2] = 16'h5312;
    mem[3] = 16'h7003; mem[7] = 16'h6123; mem[8] = 16'h700B;
    mem[4] = 16'h700E; mem[5] = 16'hF000;
    zq = {1, 1, 1, 0, 0};
    run_prog();
    wait_halt(300);
    chk("prog_a_pc", int'(bus.pc), 5);
    repeat (2) @(negedge clk);
    chk("sb_drained_a", sb.size(), 0);
    apply_reset();

    // Backward branch wraps below zero, forward branch wraps past 0xFF
    for (int i = 0; i < 256; i++) mem[i] = 16'h8000;
    mem[0] = 16'h700E; mem[255] = 16'h7001; mem[1] = 16'hF000;
    zq = {1, 1};
    run_prog();
    wait_halt(100);
    chk("wrap_pc", int'(bus.pc), 1);
    apply_reset();

    // Random program and random ack delays
    fixed = 0; zq.delete();
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
      mem[i][15:12] = 4'($urandom_range(0, 14));
    end
    nfetch = 0;
    run_prog();
    repeat (3000) @(posedge clk);
    #3 reset = 1'b1;
    #1 chk_zero("async_reset");
    chk("progress", int'(nfetch > 300), 1);
    repeat (2) @(negedge clk);

    // Fetch never acked -> error after the wait limit
    i_hold = 1;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    n = int'(bus.imem_req);
    for (int k = 0; k < 40 && !bus.err; k++) begin
      @(negedge clk);
      if (bus.imem_req) n++;
    end
    chk("err_wait_cycles", n, 15);
    chk("err_flag", int'(bus.err), 1);
    chk("err_req", int'(bus.imem_req), 0);
    chk("err_busy", int'(bus.busy), 0);
    bus.start = 1'b1;
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("err_sticky", int'(bus.err), 1);
    chk("err_start_ign", int'(bus.imem_req), 0);
    apply_reset();
    chk("err_cleared", int'(bus.err), 0);

    // Reset while a load waits in MEM
    i_hold = 0; d_hold = 1; fixed = 1;
    mem[0] = 16'h5312;
    run_prog();
    for (int k = 0; k < 20 && !bus.dmem_req; k++) @(negedge clk);
    chk("mem_reached", int'(bus.dmem_req), 1);
    repeat (2) @(negedge clk);
    we0 = we_seen;
    #2 reset = 1'b1;
    #1 chk_zero("reset_mid_mem");
    repeat (3) @(negedge clk);
    chk("no_we_after_rst", we_seen, we0);
    chk("dmem_dropped", int'(bus.dmem_req), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
